// File: rtl/pipelined_sub_constant.sv
// Free-running modulo-2^W down-counter built from two interleaved lanes.
// Each lane uses a two-cycle split subtractor, and a single-cycle reference model sets a sticky fail flag.
module pipelined_sub_constant #(
    parameter int unsigned     W    = 32,
    parameter longint unsigned C    = 2,
    parameter longint unsigned INIT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] y,
    output logic         y_vld,
    output logic         borrow,
    output logic         fail
);

    localparam int unsigned H    = W / 2;
    localparam logic [W-1:0] CW  = W'(C);
    localparam logic [W-1:0] IW  = W'(INIT);
    localparam logic [W-1:0] D2  = CW << 1;
    // A value v wrapped relative to its predecessor v+C exactly when v >= 2^W - C.
    localparam logic [W-1:0] KW  = {W{1'b0}} - CW;
    localparam logic         CNZ = (CW != {W{1'b0}});

    logic         seeded;
    logic         phase;
    logic [W-1:0] cur_e, cur_o;
    logic [H-1:0] lo_e, lo_o, hs_o;
    logic         b_e, b_o, ge_e, ge_o, brw_e, brw_o;
    logic [W-1:0] exp_y;

    logic         adv, seed;
    logic [W-1:0] seed_val;
    logic [H:0]   lo_diff_e, lo_diff_o;
    logic [H-1:0] hi_new_e, hi_new_o, lo_src_o, lo_sub_o;

    assign adv      = en | load;
    assign seed     = load | ~seeded;
    assign seed_val = load ? load_val : IW;

    // The odd lane starts from V-C, so its seed runs the low half with C instead of 2C.
    always_comb begin
        lo_diff_e = {1'b0, cur_e[H-1:0]} - {1'b0, D2[H-1:0]};
        hi_new_e  = cur_e[W-1:H] - D2[W-1:H] - H'(b_e);
        lo_src_o  = seed ? seed_val[H-1:0] : cur_o[H-1:0];
        lo_sub_o  = seed ? CW[H-1:0] : D2[H-1:0];
        lo_diff_o = {1'b0, lo_src_o} - {1'b0, lo_sub_o};
        hi_new_o  = cur_o[W-1:H] - hs_o - H'(b_o);
    end

    function automatic logic wraps(input logic [H-1:0] hi, input logic lo_ge);
        return CNZ && ((hi > KW[W-1:H]) || ((hi == KW[W-1:H]) && lo_ge));
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seeded <= 1'b0;
            phase  <= 1'b0;
            y      <= '0;
            y_vld  <= 1'b0;
            borrow <= 1'b0;
            fail   <= 1'b0;
            cur_e  <= '0;
            cur_o  <= '0;
            lo_e   <= '0;
            lo_o   <= '0;
            hs_o   <= '0;
            b_e    <= 1'b0;
            b_o    <= 1'b0;
            ge_e   <= 1'b0;
            ge_o   <= 1'b0;
            brw_e  <= 1'b0;
            brw_o  <= 1'b0;
            exp_y  <= IW;
        // NOTE: no else branch for !adv; a clocked block simply keeps its state, which is the required freeze.
        end else if (adv) begin
            if (y_vld && (y != exp_y))
                fail <= 1'b1;
            if (seed) begin
                seeded <= 1'b1;
                phase  <= 1'b0;
                y_vld  <= 1'b0;
                cur_e  <= seed_val;
                brw_e  <= 1'b0;
                cur_o  <= seed_val;
                lo_o   <= lo_diff_o[H-1:0];
                b_o    <= lo_diff_o[H];
                ge_o   <= (lo_diff_o[H-1:0] >= KW[H-1:0]);
                hs_o   <= CW[W-1:H];
                exp_y  <= seed_val;
            end else begin
                phase <= ~phase;
                y_vld <= 1'b1;
                if (y_vld)
                    exp_y <= exp_y - CW;
                // A lane runs its low half on its own output cycle and its high half on the other lane's.
                if (!phase) begin
                    y      <= cur_e;
                    borrow <= brw_e;
                    lo_e   <= lo_diff_e[H-1:0];
                    b_e    <= lo_diff_e[H];
                    ge_e   <= (lo_diff_e[H-1:0] >= KW[H-1:0]);
                    cur_o  <= {hi_new_o, lo_o};
                    brw_o  <= wraps(hi_new_o, ge_o);
                end else begin
                    y      <= cur_o;
                    borrow <= brw_o;
                    lo_o   <= lo_diff_o[H-1:0];
                    b_o    <= lo_diff_o[H];
                    ge_o   <= (lo_diff_o[H-1:0] >= KW[H-1:0]);
                    hs_o   <= D2[W-1:H];
                    cur_e  <= {hi_new_e, lo_e};
                    brw_e  <= wraps(hi_new_e, ge_e);
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_sub_constant.sv
// Bench for pipelined_sub_constant: a 32-bit C=2 instance and an 8-bit C=3 INIT=5 instance.
// It uses a directed vector table, hand-written corner sequences and long runs against a behavioural model.
module tb_pipelined_sub_constant;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        en_a, load_a, y_vld_a, borrow_a, fail_a;
    logic [31:0] load_val_a, y_a;
    logic        en_b, load_b, y_vld_b, borrow_b, fail_b;
    logic [7:0]  load_val_b, y_b;

    pipelined_sub_constant #(.W(32), .C(2), .INIT(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .load(load_a), .load_val(load_val_a),
        .y(y_a), .y_vld(y_vld_a), .borrow(borrow_a), .fail(fail_a)
    );

    pipelined_sub_constant #(.W(8), .C(3), .INIT(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .load(load_b), .load_val(load_val_b),
        .y(y_b), .y_vld(y_vld_b), .borrow(borrow_b), .fail(fail_b)
    );

    typedef struct {
        logic        en;
        logic        load;
        logic [31:0] load_val;
        logic        vld;
        logic [31:0] y;
        logic        brw;
    } vec_t;

    typedef struct {
        int          stage;
        logic [31:0] nxt;
        logic [31:0] y;
        logic        vld;
        logic        brw;
    } model_t;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        n_total++;
        if (act === want)
            n_pass++;
        else
            $display("FAIL %s: got %0h, wanted %0h", name, act, want);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic e, input logic l, input logic [31:0] lv,
                                input logic vd, input logic [31:0] yy, input logic b);
        vec_t v;
        v.en = e; v.load = l; v.load_val = lv; v.vld = vd; v.y = yy; v.brw = b;
        return v;
    endfunction

    // Behavioural sequence model: one seed cycle, then one value per advance.
    function automatic model_t model_step(input model_t m, input logic adv, input logic ld,
                                          input logic [31:0] lv, input logic [31:0] c,
                                          input logic [31:0] init, input logic [31:0] mask);
        model_t      r;
        logic [31:0] prev;
        r = m;
        if (!adv)
            return r;
        if (ld || r.stage == 0) begin
            r.nxt   = (ld ? lv : init) & mask;
            r.vld   = 1'b0;
            r.stage = 1;
        end else begin
            prev    = r.y;
            r.brw   = (r.stage == 2) && (prev < c);
            r.y     = r.nxt;
            r.vld   = 1'b1;
            r.stage = 2;
            r.nxt   = (r.y - c) & mask;
        end
        return r;
    endfunction

    vec_t        vecs[24];
    logic [7:0]  b_hand[5];
    logic        b_hand_brw[5];
    model_t      ma, mb;
    model_t      m_reset;

    initial begin
        vecs[0]  = mk(1, 0, 32'h0,   0, 32'h0,        0);
        vecs[1]  = mk(1, 0, 32'h0,   1, 32'h0,        0);
        vecs[2]  = mk(1, 0, 32'h0,   1, 32'hFFFFFFFE, 1);
        vecs[3]  = mk(1, 0, 32'h0,   1, 32'hFFFFFFFC, 0);
        vecs[4]  = mk(0, 0, 32'h0,   1, 32'hFFFFFFFC, 0);
        vecs[5]  = mk(0, 0, 32'h0,   1, 32'hFFFFFFFC, 0);
        vecs[6]  = mk(1, 0, 32'h0,   1, 32'hFFFFFFFA, 0);
        vecs[7]  = mk(1, 0, 32'h0,   1, 32'hFFFFFFF8, 0);
        vecs[8]  = mk(0, 0, 32'h0,   1, 32'hFFFFFFF8, 0);
        vecs[9]  = mk(1, 0, 32'h0,   1, 32'hFFFFFFF6, 0);
        vecs[10] = mk(1, 1, 32'h100, 0, 32'h0,        0);
        vecs[11] = mk(1, 0, 32'h0,   1, 32'h100,      0);
        vecs[12] = mk(0, 0, 32'h0,   1, 32'h100,      0);
        vecs[13] = mk(1, 0, 32'h0,   1, 32'hFE,       0);
        vecs[14] = mk(1, 0, 32'h0,   1, 32'hFC,       0);
        vecs[15] = mk(0, 1, 32'h1,   0, 32'h0,        0);
        vecs[16] = mk(0, 0, 32'h0,   0, 32'h0,        0);
        vecs[17] = mk(1, 0, 32'h0,   1, 32'h1,        0);
        vecs[18] = mk(1, 0, 32'h0,   1, 32'hFFFFFFFF, 1);
        vecs[19] = mk(1, 0, 32'h0,   1, 32'hFFFFFFFD, 0);
        vecs[20] = mk(1, 1, 32'h3,   0, 32'h0,        0);
        vecs[21] = mk(1, 1, 32'h10,  0, 32'h0,        0);
        vecs[22] = mk(1, 0, 32'h0,   1, 32'h10,       0);
        vecs[23] = mk(1, 0, 32'h0,   1, 32'hE,        0);

        b_hand[0] = 8'h05; b_hand_brw[0] = 1'b0;
        b_hand[1] = 8'h02; b_hand_brw[1] = 1'b0;
        b_hand[2] = 8'hFF; b_hand_brw[2] = 1'b1;
        b_hand[3] = 8'hFC; b_hand_brw[3] = 1'b0;
        b_hand[4] = 8'hF9; b_hand_brw[4] = 1'b0;

        m_reset = '{stage: 0, nxt: 32'h0, y: 32'h0, vld: 1'b0, brw: 1'b0};

        rst_n = 1'b0;
        en_a = 1'b0; load_a = 1'b0; load_val_a = '0;
        en_b = 1'b0; load_b = 1'b0; load_val_b = '0;
        repeat (3) step();
        check("reset y", y_a, 0);
        check("reset y_vld", y_vld_a, 0);
        check("reset borrow", borrow_a, 0);
        check("reset fail", fail_a, 0);
        check("reset b y_vld", y_vld_b, 0);
        check("reset b fail", fail_b, 0);

        // Directed table on the 32-bit instance: startup, stalls, loads.
        rst_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            en_a = vecs[i].en; load_a = vecs[i].load; load_val_a = vecs[i].load_val;
            step();
            check($sformatf("vec%0d y_vld", i), y_vld_a, vecs[i].vld);
            if (vecs[i].vld) begin
                check($sformatf("vec%0d y", i), y_a, vecs[i].y);
                check($sformatf("vec%0d borrow", i), borrow_a, vecs[i].brw);
            end
            check($sformatf("vec%0d fail", i), fail_a, 0);
        end

        // Asynchronous reset between edges, then restart from INIT.
        load_a = 1'b0; en_a = 1'b1;
        repeat (5) step();
        #3;
        rst_n = 1'b0;
        #1;
        check("async y", y_a, 0);
        check("async y_vld", y_vld_a, 0);
        check("async borrow", borrow_a, 0);
        check("async fail", fail_a, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("restart y_vld first edge", y_vld_a, 0);
        step();
        check("restart y_vld", y_vld_a, 1);
        check("restart y", y_a, 0);
        check("restart fail", fail_a, 0);

        // Load on the very first cycle after reset beats INIT.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; en_a = 1'b0; load_a = 1'b1; load_val_a = 32'h55;
        step();
        check("first load y_vld", y_vld_a, 0);
        load_a = 1'b0; en_a = 1'b1;
        step();
        check("first load y", y_a, 32'h55);
        check("first load y_vld2", y_vld_a, 1);
        check("first load borrow", borrow_a, 0);
        step();
        check("first load next", y_a, 32'h53);

        // Long random-stall run on the 32-bit instance against the model.
        rst_n = 1'b0;
        step();
        ma = m_reset;
        rst_n = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            en_a       = ($urandom_range(0, 3) != 0);
            load_a     = ($urandom_range(0, 63) == 0);
            load_val_a = $urandom;
            ma = model_step(ma, en_a | load_a, load_a, load_val_a, 32'd2, 32'd0, 32'hFFFFFFFF);
            step();
            check($sformatf("run%0d y_vld", i), y_vld_a, ma.vld);
            if (ma.vld) begin
                check($sformatf("run%0d y", i), y_a, ma.y);
                check($sformatf("run%0d borrow", i), borrow_a, ma.brw);
            end
            check($sformatf("run%0d fail", i), fail_a, 0);
        end
        en_a = 1'b0; load_a = 1'b0;

        // 8-bit instance: full wrap back to INIT after 256 steps.
        rst_n = 1'b0;
        step();
        mb = m_reset;
        rst_n = 1'b1; en_b = 1'b1;
        mb = model_step(mb, 1'b1, 1'b0, 32'h0, 32'd3, 32'd5, 32'hFF);
        step();
        check("b seed y_vld", y_vld_b, 0);
        for (int k = 0; k <= 256; k++) begin
            mb = model_step(mb, 1'b1, 1'b0, 32'h0, 32'd3, 32'd5, 32'hFF);
            step();
            if (k < 5) begin
                check($sformatf("b hand%0d y", k), y_b, b_hand[k]);
                check($sformatf("b hand%0d borrow", k), borrow_b, b_hand_brw[k]);
            end
            check($sformatf("b step%0d y", k), y_b, mb.y);
            check($sformatf("b step%0d borrow", k), borrow_b, mb.brw);
            check($sformatf("b step%0d y_vld", k), y_vld_b, 1);
        end
        check("b wrap y", y_b, 8'h05);
        check("b wrap fail", fail_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
